// File: rtl/cpu_pkg.sv
// Shared constants for the 4-bit CPU core: machine-cycle phases, PC width,
// and the opcode/sub-opcode encodings understood by the sequencer.
package cpu_pkg;

  localparam int unsigned PC_WIDTH = 12;

  // Eight-phase machine cycle; A1 starts a cycle, X3 ends it.
  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  // OPR (upper nibble) encodings
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_JUN = 4'h4;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_LDM = 4'hD;
  localparam logic [3:0] OP_ACC = 4'hF;

  // OPA sub-opcodes within the accumulator group (OPR = OP_ACC)
  localparam logic [3:0] ACC_CLB = 4'h0;
  localparam logic [3:0] ACC_CLC = 4'h1;

endpackage

// File: rtl/instruction_decoder.sv
// Combinational decode of the latched instruction byte into datapath strobes.
//   execute            : high only in the X1 phase; gates every strobe
//   jun_pending        : current byte is JUN word 2 (address data, not decoded)
//   opr, opa           : latched instruction nibbles
//   clear_carry, clear_accumulator, write_accumulator, write_register : strobes
//   acc_input_sel      : 1 = register file, 0 = immediate OPA
module instruction_decoder
  import cpu_pkg::*;
(
  input  logic       execute,
  input  logic       jun_pending,
  input  logic [3:0] opr,
  input  logic [3:0] opa,
  output logic       clear_carry,
  output logic       clear_accumulator,
  output logic       write_accumulator,
  output logic       acc_input_sel,
  output logic       write_register
);

  always_comb begin
    clear_carry       = 1'b0;
    clear_accumulator = 1'b0;
    write_accumulator = 1'b0;
    acc_input_sel     = 1'b0;
    write_register    = 1'b0;
    if (execute && !jun_pending) begin
      case (opr)
        OP_LDM: write_accumulator = 1'b1;
        OP_LD: begin
          write_accumulator = 1'b1;
          acc_input_sel     = 1'b1;
        end
        OP_ST: write_register = 1'b1;
        OP_ACC: begin
          if (opa == ACC_CLB) begin
            clear_accumulator = 1'b1;
            clear_carry       = 1'b1;
          end else if (opa == ACC_CLC) begin
            clear_carry = 1'b1;
          end
        end
        // OP_NOP, OP_JUN word 1 and undefined encodings drive nothing
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control.sv
// Instruction sequencer: runs the 8-phase machine cycle, emits the PC as
// three address nibbles, fetches OPR/OPA from the ROM nibble bus, and drives
// one-clock X1 strobes into the datapath. Owns the PC and JUN sequencing.
//   clock, reset      : system clock, synchronous active-high reset
//   rom_data          : ROM nibble (OPR at end of M1, OPA at end of M2)
//   addr_nibble       : pc nibble in A1/A2/A3, 0 otherwise
//   sync              : high in X3
//   phase, pc         : current phase (A1 = 0) and program counter
//   strobes           : clear_carry, clear_accumulator, write_accumulator,
//                       acc_input_sel, write_register, reg_input_sel (always 0)
//   inst_operand      : latched OPA
module control
  import cpu_pkg::*;
#(
  parameter logic [PC_WIDTH-1:0] PC_RESET = 12'h000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [3:0]          rom_data,
  output logic [3:0]          addr_nibble,
  output logic                sync,
  output logic [2:0]          phase,
  output logic [PC_WIDTH-1:0] pc,
  output logic                clear_carry,
  output logic                clear_accumulator,
  output logic                write_accumulator,
  output logic                acc_input_sel,
  output logic                write_register,
  output logic                reg_input_sel,
  output logic [3:0]          inst_operand
);

  phase_t              ph;
  logic [PC_WIDTH-1:0] pc_q;
  logic [3:0]          opr;
  logic [3:0]          opa;
  logic [3:0]          jump_hi;
  logic                jun_pending;

  always_ff @(posedge clock) begin
    if (reset) begin
      ph          <= PH_A1;
      pc_q        <= PC_RESET;
      opr         <= '0;
      opa         <= '0;
      jump_hi     <= '0;
      jun_pending <= 1'b0;
    end else begin
      ph <= phase_t'(ph + 3'd1);
      case (ph)
        PH_M1: opr <= rom_data;
        PH_M2: begin
          opa  <= rom_data;
          pc_q <= pc_q + 12'd1;
        end
        PH_X1: begin
          // Word 2 of JUN carries the low address byte; loading here
          // supersedes the M2 increment so the next A1 emits the target.
          if (jun_pending) begin
            pc_q        <= {jump_hi, opr, opa};
            jun_pending <= 1'b0;
          end else if (opr == OP_JUN) begin
            jump_hi     <= opa;
            jun_pending <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (ph)
      PH_A1:   addr_nibble = pc_q[3:0];
      PH_A2:   addr_nibble = pc_q[7:4];
      PH_A3:   addr_nibble = pc_q[11:8];
      default: addr_nibble = '0;
    endcase
  end

  assign sync          = (ph == PH_X3);
  assign phase         = ph;
  assign pc            = pc_q;
  assign inst_operand  = opa;
  assign reg_input_sel = 1'b0;

  instruction_decoder u_decoder (
    .execute           (ph == PH_X1),
    .jun_pending       (jun_pending),
    .opr               (opr),
    .opa               (opa),
    .clear_carry       (clear_carry),
    .clear_accumulator (clear_accumulator),
    .write_accumulator (write_accumulator),
    .acc_input_sel     (acc_input_sel),
    .write_register    (write_register)
  );

endmodule

// File: tb/tb_control.sv
// Bench for control: a ROM addressed from the emitted nibbles, a tiny
// accumulator/register datapath, and a per-cycle reference model of the
// instruction sequence (whole-byte fetch, next-PC rule, JUN two-word rule).
module tb_control;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rom_data;
  logic [3:0]  addr_nibble;
  logic        sync;
  logic [2:0]  phase;
  logic [11:0] pc;
  logic        clear_carry, clear_accumulator, write_accumulator;
  logic        acc_input_sel, write_register, reg_input_sel;
  logic [3:0]  inst_operand;

  control #(.PC_RESET(12'h000)) dut (
    .clock             (clock),
    .reset             (reset),
    .rom_data          (rom_data),
    .addr_nibble       (addr_nibble),
    .sync              (sync),
    .phase             (phase),
    .pc                (pc),
    .clear_carry       (clear_carry),
    .clear_accumulator (clear_accumulator),
    .write_accumulator (write_accumulator),
    .acc_input_sel     (acc_input_sel),
    .write_register    (write_register),
    .reg_input_sel     (reg_input_sel),
    .inst_operand      (inst_operand)
  );

  always #5 clock = ~clock;

  // ROM: address assembled from A1..A3 nibbles, byte served as two nibbles
  logic [7:0]  rom [4096];
  logic [11:0] rom_addr = '0;
  always @(posedge clock) begin
    if (phase == 3'd0) rom_addr[3:0]  <= addr_nibble;
    if (phase == 3'd1) rom_addr[7:4]  <= addr_nibble;
    if (phase == 3'd2) rom_addr[11:8] <= addr_nibble;
  end
  assign rom_data = (phase == 3'd3) ? rom[rom_addr][7:4] : rom[rom_addr][3:0];

  // Small datapath driven by the strobes
  logic [3:0] acc = '0;
  logic [3:0] regs [16];
  always @(posedge clock) begin
    if (clear_accumulator) acc <= '0;
    else if (write_accumulator) acc <= acc_input_sel ? regs[inst_operand] : inst_operand;
    if (write_register) regs[inst_operand] <= acc;
  end

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state: clock index within cycle, PC at cycle start,
  // whether this cycle carries JUN word 2, jump high nibble, previous OPA.
  int unsigned m_k;
  logic [11:0] m_cur;
  logic        m_jun;
  logic [3:0]  m_hi;
  logic [3:0]  m_prev;

  task automatic model_reset();
    m_k = 0; m_cur = 12'h000; m_jun = 1'b0; m_hi = '0; m_prev = '0;
  endtask

  // {clear_carry, clear_accumulator, write_accumulator, acc_input_sel, write_register}
  function automatic logic [4:0] exp_strobes(input logic [7:0] b, input logic word2);
    if (word2) return 5'b0;
    case (b[7:4])
      4'hD: return 5'b00100;
      4'hA: return 5'b00110;
      4'hB: return 5'b00001;
      4'hF: return (b[3:0] == 4'h0) ? 5'b11000 : (b[3:0] == 4'h1) ? 5'b10000 : 5'b0;
      default: return 5'b0;
    endcase
  endfunction

  task automatic check_now();
    logic [7:0]  b;
    logic [11:0] exp_pc;
    logic [3:0]  exp_addr;
    b = rom[m_cur];
    exp_pc = (m_k <= 4) ? m_cur : (m_k >= 6 && m_jun) ? {m_hi, b} : m_cur + 12'd1;
    exp_addr = (m_k == 0) ? m_cur[3:0] : (m_k == 1) ? m_cur[7:4] :
               (m_k == 2) ? m_cur[11:8] : 4'h0;
    cmp("phase", 16'(phase), 16'(m_k));
    cmp("addr_nibble", 16'(addr_nibble), 16'(exp_addr));
    cmp("sync", 16'(sync), 16'(m_k == 7));
    cmp("pc", 16'(pc), 16'(exp_pc));
    cmp("strobes", 16'({clear_carry, clear_accumulator, write_accumulator, acc_input_sel, write_register}),
        16'((m_k == 5) ? exp_strobes(b, m_jun) : 5'b0));
    cmp("reg_input_sel", 16'(reg_input_sel), 16'h0);
    cmp("inst_operand", 16'(inst_operand), 16'((m_k >= 5) ? b[3:0] : m_prev));
  endtask

  task automatic model_advance();
    logic [7:0] b;
    if (m_k == 7) begin
      b = rom[m_cur];
      if (m_jun) begin
        m_cur = {m_hi, b};
        m_jun = 1'b0;
      end else begin
        if (b[7:4] == 4'h4) begin
          m_hi  = b[3:0];
          m_jun = 1'b1;
        end
        m_cur = m_cur + 12'd1;
      end
      m_prev = b[3:0];
    end
    m_k = (m_k + 1) % 8;
  endtask

  // Called at a negedge: check, advance the model, move to the next negedge
  task automatic step(input int unsigned n = 1);
    for (int unsigned i = 0; i < n; i++) begin
      check_now();
      if (reset) model_reset();
      else model_advance();
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    acc = '0;
    model_reset();
  endtask

  task automatic clear_rom();
    foreach (rom[i]) rom[i] = 8'h00;
  endtask

  initial begin
    foreach (regs[i]) regs[i] = '0;
    clear_rom();
    @(negedge clock);

    // Idle NOPs: addresses 0 then 1, sync in phase 7 only, no strobes
    do_reset();
    cmp("reset_pc", 16'(pc), 16'h000);
    cmp("reset_phase", 16'(phase), 16'h0);
    step(16);
    cmp("idle_pc", 16'(pc), 16'h002);

    // LDM 7
    clear_rom(); rom[0] = 8'hD7;
    do_reset();
    step(5);
    cmp("ldm_wa", 16'(write_accumulator), 16'h1);
    cmp("ldm_operand", 16'(inst_operand), 16'h7);
    step(3);
    cmp("ldm_acc", 16'(acc), 16'h7);

    // LDM 5; ST R3; LDM 0; LD R3
    clear_rom(); rom[0] = 8'hD5; rom[1] = 8'hB3; rom[2] = 8'hD0; rom[3] = 8'hA3;
    do_reset();
    step(13);
    cmp("st_wr", 16'(write_register), 16'h1);
    cmp("st_operand", 16'(inst_operand), 16'h3);
    step(19);
    cmp("ld_acc", 16'(acc), 16'h5);

    // JUN 0xABC
    clear_rom(); rom[0] = 8'h4A; rom[1] = 8'hBC;
    do_reset();
    step(16);
    cmp("jun_pc", 16'(pc), 16'hABC);
    step(8);

    // CLB, CLC
    clear_rom(); rom[0] = 8'hD9; rom[1] = 8'hF0; rom[2] = 8'hF1;
    do_reset();
    step(13);
    cmp("clb_ca", 16'(clear_accumulator), 16'h1);
    step(8);
    cmp("clc_ca", 16'(clear_accumulator), 16'h0);
    step(3);
    cmp("clb_acc", 16'(acc), 16'h0);

    // Reset in M2 of JUN word 2
    clear_rom(); rom[0] = 8'h4A; rom[1] = 8'hBC;
    do_reset();
    step(12);
    rom[0] = 8'hD1;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    cmp("midjun_pc", 16'(pc), 16'h000);
    step(5);
    cmp("midjun_wa", 16'(write_accumulator), 16'h1);
    step(3);

    // JUN to 0xFFF holding NOP, wraps to 0; undefined 0xE3 does nothing
    clear_rom(); rom[0] = 8'h4F; rom[1] = 8'hFF; rom[12'hFFF] = 8'h00; rom[2] = 8'hE3;
    do_reset();
    step(24);
    cmp("wrap_pc", 16'(pc), 16'h000);
    step(8);

    // Randomized program with a reset partway through
    foreach (rom[i]) begin
      logic [3:0] r;
      r = 4'($urandom);
      case ($urandom_range(0, 9))
        0: rom[i] = 8'h00;
        1: rom[i] = {4'hD, r};
        2: rom[i] = {4'hA, r};
        3: rom[i] = {4'hB, r};
        4: rom[i] = 8'hF0;
        5: rom[i] = 8'hF1;
        6: rom[i] = {4'h4, r};
        default: rom[i] = 8'($urandom);
      endcase
    end
    do_reset();
    step(1500 + $urandom_range(0, 7));
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    step(1500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
